// File: rtl/vram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared definitions for the VRAM bus arbiter: default bus widths and
// timing parameters, the 3-bit FSM state encodings, and a saturating
// increment helper for the 8-bit collision counter.
// ---------------------------------------------------------------------------
package vram_arbiter_pkg;

  localparam int ADDR_W_DEF        = 24;
  localparam int DATA_W_DEF        = 8;
  localparam int ACCESS_CYCLES_DEF = 2;
  localparam int TIMEOUT_DEF       = 1023;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_ACCESS = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Shares the VRAM bus between display scanout (absolute priority) and host
// CPU read/write cycles. Host accesses are slotted into blanking time,
// sequenced through SETUP/ACCESS, and completed with an active-low ack.
//
// Ports
//   clk_main       in   system clock, rising edge
//   reset_in       in   synchronous active-high reset
//   disp_active_n  in   0 = display owns the bus this cycle
//   disp_hold      in   1 = display resumes soon; no new host access may start
//   disp_addr      in   scanout fetch address
//   host_sel_n     in   active-low host request, held until ack seen
//   host_rw        in   1 = read, 0 = write (sampled with request)
//   host_addr      in   host VRAM address (sampled with request)
//   host_wdata     in   host write data (sampled with request)
//   host_rdata     out  read data, valid while host_ack_n = 0
//   host_ack_n     out  active-low acknowledge
//   host_err       out  1 with ack when the request timed out
//   vram_addr      out  VRAM address pins
//   vram_wdata     out  VRAM write data
//   vram_we_n      out  VRAM write strobe, active low
//   vram_oe_n      out  VRAM output enable, active low
//   vram_rdata     in   VRAM read data
//   collision_cnt  out  saturating count of aborted host accesses
// ---------------------------------------------------------------------------
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF
) (
  input  logic              clk_main,
  input  logic              reset_in,
  input  logic              disp_active_n,
  input  logic              disp_hold,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              host_sel_n,
  input  logic              host_rw,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack_n,
  output logic              host_err,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wdata,
  output logic              vram_we_n,
  output logic              vram_oe_n,
  input  logic [DATA_W-1:0] vram_rdata,
  output logic [7:0]        collision_cnt
);

  localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int ACW = (ACCESS_CYCLES < 2) ? 1 : $clog2(ACCESS_CYCLES);

  logic [2:0]        state, state_nxt;
  logic              lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              withdrawn;
  logic [WCW-1:0]    wait_cnt;
  logic [WCW-1:0]    wait_inc;
  logic [ACW-1:0]    acc_cnt;

  logic grantable;
  logic on_bus;
  logic collide;
  logic acc_last;
  logic wait_expired;
  logic withdrawn_now;

  assign grantable     = disp_active_n && !disp_hold;
  assign on_bus        = (state == ST_SETUP) || (state == ST_ACCESS);
  assign collide       = on_bus && !disp_active_n;
  assign acc_last      = (acc_cnt == ACW'(ACCESS_CYCLES - 1));
  assign wait_inc      = wait_cnt + WCW'(1);
  assign wait_expired  = (wait_inc >= WCW'(TIMEOUT));
  // A host that lets go mid-access still gets its access finished, but no ack.
  assign withdrawn_now = withdrawn || host_sel_n;

  // The host owns the address pins only while its access is on the bus.
  assign vram_addr  = on_bus ? lat_addr : disp_addr;
  assign vram_wdata = lat_wdata;

  // Next-state logic. In WAIT a withdrawn request is dropped first, and a
  // grant beats a timeout that lands on the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!host_sel_n) state_nxt = grantable ? ST_SETUP : ST_WAIT;
      end
      ST_WAIT: begin
        if (host_sel_n)        state_nxt = ST_IDLE;
        else if (grantable)    state_nxt = ST_SETUP;
        else if (wait_expired) state_nxt = ST_DONE;
      end
      ST_SETUP: begin
        state_nxt = collide ? ST_WAIT : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (collide)       state_nxt = ST_WAIT;
        else if (acc_last) state_nxt = withdrawn_now ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        if (host_sel_n) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobes and ack are registered from the next state, so they can only
  // ever be low while the FSM actually sits in ACCESS (or DONE for ack).
  always_ff @(posedge clk_main) begin
    if (reset_in) begin
      state         <= ST_IDLE;
      lat_rw        <= 1'b1;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      withdrawn     <= 1'b0;
      wait_cnt      <= '0;
      acc_cnt       <= '0;
      host_rdata    <= '0;
      host_ack_n    <= 1'b1;
      host_err      <= 1'b0;
      vram_we_n     <= 1'b1;
      vram_oe_n     <= 1'b1;
      collision_cnt <= 8'd0;
    end else begin
      state      <= state_nxt;
      vram_oe_n  <= !((state_nxt == ST_ACCESS) && lat_rw);
      vram_we_n  <= !((state_nxt == ST_ACCESS) && !lat_rw);
      host_ack_n <= !(state_nxt == ST_DONE);

      if ((state == ST_WAIT) && (state_nxt == ST_DONE)) host_err <= 1'b1;
      else if (state_nxt != ST_DONE)                    host_err <= 1'b0;

      if ((state == ST_IDLE) && !host_sel_n) begin
        lat_rw    <= host_rw;
        lat_addr  <= host_addr;
        lat_wdata <= host_wdata;
        withdrawn <= 1'b0;
        wait_cnt  <= '0;
      end

      // The wait count spans collisions so retries cannot extend the timeout.
      if (state == ST_WAIT) wait_cnt <= wait_inc;

      if (on_bus) withdrawn <= withdrawn_now;

      if (state == ST_ACCESS) acc_cnt <= acc_cnt + ACW'(1);
      else                    acc_cnt <= '0;

      if (collide) collision_cnt <= sat_inc8(collision_cnt);

      if ((state == ST_ACCESS) && acc_last && !collide && lat_rw)
        host_rdata <= vram_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
// Self-checking bench for vram_arbiter. A default-timing instance covers
// reads, writes, display priority, collisions, withdrawal and back-to-back
// requests; a second instance with TIMEOUT=15 covers the error-ack path.
// Expected host results are queued when a request is driven and popped
// when the DUT acknowledges.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

  logic        clk_main;
  logic        reset_in;
  logic        disp_active_n;
  logic        disp_hold;
  logic [23:0] disp_addr;
  logic        host_sel_n;
  logic        host_rw;
  logic [23:0] host_addr;
  logic [7:0]  host_wdata;
  logic [7:0]  vram_rdata;

  logic [7:0]  host_rdata,  host_rdata_to;
  logic        host_ack_n,  host_ack_n_to;
  logic        host_err,    host_err_to;
  logic [23:0] vram_addr,   vram_addr_to;
  logic [7:0]  vram_wdata,  vram_wdata_to;
  logic        vram_we_n,   vram_we_n_to;
  logic        vram_oe_n,   vram_oe_n_to;
  logic [7:0]  collision_cnt, collision_cnt_to;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
    logic       chk_rd;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_bad = 0;

  vram_arbiter dut (
    .clk_main(clk_main), .reset_in(reset_in),
    .disp_active_n(disp_active_n), .disp_hold(disp_hold), .disp_addr(disp_addr),
    .host_sel_n(host_sel_n), .host_rw(host_rw), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack_n(host_ack_n),
    .host_err(host_err), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_we_n(vram_we_n), .vram_oe_n(vram_oe_n), .vram_rdata(vram_rdata),
    .collision_cnt(collision_cnt)
  );

  vram_arbiter #(.TIMEOUT(15)) dut_to (
    .clk_main(clk_main), .reset_in(reset_in),
    .disp_active_n(disp_active_n), .disp_hold(disp_hold), .disp_addr(disp_addr),
    .host_sel_n(host_sel_n), .host_rw(host_rw), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata_to), .host_ack_n(host_ack_n_to),
    .host_err(host_err_to), .vram_addr(vram_addr_to), .vram_wdata(vram_wdata_to),
    .vram_we_n(vram_we_n_to), .vram_oe_n(vram_oe_n_to), .vram_rdata(vram_rdata),
    .collision_cnt(collision_cnt_to)
  );

  initial clk_main = 1'b0;
  always #5 clk_main = ~clk_main;

  // Both strobes low at once would short the VRAM data bus.
  always @(negedge clk_main) begin
    if (!reset_in && ((!vram_we_n && !vram_oe_n) || (!vram_we_n_to && !vram_oe_n_to)))
      strobe_bad++;
  end

  task automatic tick;
    @(posedge clk_main);
    #1;
  endtask

  task automatic do_reset;
    reset_in      = 1'b1;
    host_sel_n    = 1'b1;
    disp_active_n = 1'b1;
    disp_hold     = 1'b0;
    tick;
    tick;
    reset_in = 1'b0;
  endtask

  // Drives one host request, follows it until ack or budget, then releases.
  task automatic host_xfer(input logic rw, input logic [23:0] addr, input logic [7:0] wd,
                           input int budget, output int ack_cycle, output int oe_low,
                           output int we_low, output logic bus_ok, output logic [7:0] rd,
                           output logic er, output logic ack_n_after);
    ack_cycle = 0; oe_low = 0; we_low = 0; bus_ok = 1'b1; rd = '0; er = 1'b0;
    host_rw = rw; host_addr = addr; host_wdata = wd; host_sel_n = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      tick;
      if (!vram_oe_n) oe_low++;
      if (!vram_we_n) we_low++;
      if ((!vram_oe_n || !vram_we_n) && ((vram_addr !== addr) || (vram_wdata !== wd)))
        bus_ok = 1'b0;
      if (!host_ack_n) begin
        ack_cycle = k; rd = host_rdata; er = host_err;
        break;
      end
    end
    host_sel_n = 1'b1;
    tick;
    ack_n_after = host_ack_n;
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++;
    if ({host_ack_n, host_err, vram_we_n, vram_oe_n} !== 4'b1011) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got ack_n/err/we_n/oe_n=%b expected 1011",
               {host_ack_n, host_err, vram_we_n, vram_oe_n});
    end
    n_checks++;
    if ((host_rdata !== 8'h00) || (collision_cnt !== 8'h00)) begin
      n_fail++;
      $display("[TB] FAIL reset_regs: got rdata=%h coll=%0d expected 00/0", host_rdata, collision_cnt);
    end
    disp_addr = 24'hABCDEF;
    #1;
    n_checks++;
    if (vram_addr !== 24'hABCDEF) begin
      n_fail++;
      $display("[TB] FAIL reset_addr: got %h expected abcdef", vram_addr);
    end
  endtask

  task automatic test_read;
    int ac, ol, wl; logic ok, er, an; logic [7:0] rd; exp_t e;
    vram_rdata = 8'h5A;
    sb.push_back('{rdata: 8'h5A, err: 1'b0, chk_rd: 1'b1});
    host_xfer(1'b1, 24'h000123, 8'h00, 10, ac, ol, wl, ok, rd, er, an);
    n_checks++;
    if (ac != 4) begin n_fail++; $display("[TB] FAIL read_ack_cycle: got %0d expected 4", ac); end
    n_checks++;
    if ((ol != 2) || (wl != 0) || !ok) begin
      n_fail++; $display("[TB] FAIL read_strobes: got oe_low=%0d we_low=%0d bus_ok=%b expected 2/0/1", ol, wl, ok);
    end
    e = sb.pop_front();
    n_checks++;
    if ((rd !== e.rdata) || (er !== e.err)) begin
      n_fail++; $display("[TB] FAIL read_data: got %h err=%b expected %h err=%b", rd, er, e.rdata, e.err);
    end
    n_checks++;
    if (an !== 1'b1) begin n_fail++; $display("[TB] FAIL read_release: got ack_n=%b expected 1", an); end
  endtask

  task automatic test_write;
    int ac, ol, wl; logic ok, er, an; logic [7:0] rd; exp_t e;
    sb.push_back('{rdata: 8'h00, err: 1'b0, chk_rd: 1'b0});
    host_xfer(1'b0, 24'h00FFFF, 8'hC3, 10, ac, ol, wl, ok, rd, er, an);
    n_checks++;
    if ((ac != 4) || (wl != 2) || (ol != 0) || !ok) begin
      n_fail++;
      $display("[TB] FAIL write_cycle: got ack=%0d we_low=%0d oe_low=%0d bus_ok=%b expected 4/2/0/1", ac, wl, ol, ok);
    end
    e = sb.pop_front();
    n_checks++;
    if ((er !== e.err) || (e.chk_rd && (rd !== e.rdata)) || (an !== 1'b1)) begin
      n_fail++; $display("[TB] FAIL write_ack: got err=%b ack_n_after=%b expected %b/1", er, an, e.err);
    end
  endtask

  task automatic test_priority;
    int bad, ac, ol, wl; logic ok, er, an; logic [7:0] rd; exp_t e;
    bad = 0;
    disp_active_n = 1'b0;
    disp_addr     = 24'h777777;
    vram_rdata    = 8'h96;
    host_rw = 1'b1; host_addr = 24'h000042; host_sel_n = 1'b0;
    sb.push_back('{rdata: 8'h96, err: 1'b0, chk_rd: 1'b1});
    for (int k = 0; k < 50; k++) begin
      tick;
      if (!vram_we_n || !vram_oe_n || !host_ack_n || (vram_addr !== 24'h777777)) bad++;
    end
    // Display gone but the guard window still open: still no host access.
    disp_active_n = 1'b1;
    disp_hold     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (!vram_we_n || !vram_oe_n || !host_ack_n || (vram_addr !== 24'h777777)) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("[TB] FAIL prio_hold_off: got %0d bad cycles expected 0", bad); end
    disp_hold = 1'b0;
    host_xfer(1'b1, 24'h000042, host_wdata, 10, ac, ol, wl, ok, rd, er, an);
    e = sb.pop_front();
    n_checks++;
    if ((ac != 4) || (ol != 2) || !ok || (rd !== e.rdata) || (er !== e.err)) begin
      n_fail++;
      $display("[TB] FAIL prio_grant: got ack=%0d oe_low=%0d ok=%b rd=%h err=%b expected 4/2/1/%h/%b",
               ac, ol, ok, rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_collision;
    int ac, wl; exp_t e; logic er;
    ac = 0; wl = 0; er = 1'b0;
    sb.push_back('{rdata: 8'h00, err: 1'b0, chk_rd: 1'b0});
    host_rw = 1'b0; host_addr = 24'h000800; host_wdata = 8'h11; host_sel_n = 1'b0;
    tick;
    tick;
    n_checks++;
    if (vram_we_n !== 1'b0) begin n_fail++; $display("[TB] FAIL coll_pre: got we_n=%b expected 0", vram_we_n); end
    disp_active_n = 1'b0;
    tick;
    n_checks++;
    if ((vram_we_n !== 1'b1) || (vram_oe_n !== 1'b1) || (collision_cnt !== 8'd1)) begin
      n_fail++;
      $display("[TB] FAIL coll_abort: got we_n=%b oe_n=%b coll=%0d expected 1/1/1", vram_we_n, vram_oe_n, collision_cnt);
    end
    disp_active_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick;
      if (!vram_we_n) wl++;
      if (!host_ack_n) begin ac = k; er = host_err; break; end
    end
    host_sel_n = 1'b1;
    tick;
    e = sb.pop_front();
    n_checks++;
    if ((ac != 4) || (wl != 2) || (er !== e.err) || (collision_cnt !== 8'd1)) begin
      n_fail++;
      $display("[TB] FAIL coll_retry: got ack=%0d we_low=%0d err=%b coll=%0d expected 4/2/%b/1", ac, wl, er, collision_cnt, e.err);
    end
  endtask

  task automatic test_withdraw;
    int wl, acks;
    wl = 0; acks = 0;
    host_rw = 1'b0; host_addr = 24'h000456; host_wdata = 8'h9E; host_sel_n = 1'b0;
    tick;
    tick;
    if (!vram_we_n) wl++;
    host_sel_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (!vram_we_n) wl++;
      if (!host_ack_n) acks++;
    end
    n_checks++;
    if ((wl != 2) || (acks != 0)) begin
      n_fail++; $display("[TB] FAIL withdraw: got we_low=%0d ack_cycles=%0d expected 2/0", wl, acks);
    end
  endtask

  task automatic test_back_to_back;
    int ol, first_ack, ac, wl; logic ok, er, an; logic [7:0] rd; exp_t e;
    ol = 0; first_ack = 0;
    vram_rdata = 8'h3C;
    sb.push_back('{rdata: 8'h3C, err: 1'b0, chk_rd: 1'b1});
    host_rw = 1'b1; host_addr = 24'h000010; host_sel_n = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick;
      if (!vram_oe_n) ol++;
      if (!host_ack_n && (first_ack == 0)) first_ack = k;
    end
    e = sb.pop_front();
    n_checks++;
    if ((first_ack != 4) || (ol != 2) || (host_ack_n !== 1'b0) || (host_rdata !== e.rdata)) begin
      n_fail++;
      $display("[TB] FAIL b2b_hold: got ack=%0d oe_low=%0d ack_n=%b rd=%h expected 4/2/0/%h",
               first_ack, ol, host_ack_n, host_rdata, e.rdata);
    end
    host_sel_n = 1'b1;
    tick;
    n_checks++;
    if (host_ack_n !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_release: got ack_n=%b expected 1", host_ack_n); end
    vram_rdata = 8'hE1;
    sb.push_back('{rdata: 8'hE1, err: 1'b0, chk_rd: 1'b1});
    host_xfer(1'b1, 24'h000020, 8'h00, 10, ac, ol, wl, ok, rd, er, an);
    e = sb.pop_front();
    n_checks++;
    if ((ac != 4) || (ol != 2) || !ok || (rd !== e.rdata) || (an !== 1'b1)) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: got ack=%0d oe_low=%0d ok=%b rd=%h ack_n_after=%b expected 4/2/1/%h/1",
               ac, ol, ok, rd, an, e.rdata);
    end
  endtask

  task automatic test_reset_mid_write;
    host_rw = 1'b0; host_addr = 24'h00ABCD; host_wdata = 8'h55; host_sel_n = 1'b0;
    disp_addr = 24'h123456;
    tick;
    tick;
    n_checks++;
    if (vram_we_n !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_pre: got we_n=%b expected 0", vram_we_n); end
    reset_in = 1'b1;
    tick;
    n_checks++;
    if ((vram_we_n !== 1'b1) || (host_ack_n !== 1'b1) || (collision_cnt !== 8'd0) ||
        (vram_addr !== 24'h123456)) begin
      n_fail++;
      $display("[TB] FAIL rst_mid: got we_n=%b ack_n=%b coll=%0d addr=%h expected 1/1/0/123456",
               vram_we_n, host_ack_n, collision_cnt, vram_addr);
    end
    reset_in   = 1'b0;
    host_sel_n = 1'b1;
    tick;
    tick;
    n_checks++;
    if ((vram_we_n !== 1'b1) || (host_ack_n !== 1'b1)) begin
      n_fail++; $display("[TB] FAIL rst_after: got we_n=%b ack_n=%b expected 1/1", vram_we_n, host_ack_n);
    end
  endtask

  task automatic test_timeout;
    int ac, strobes; exp_t e; logic er, main_ack_n;
    ac = 0; strobes = 0; er = 1'b0; main_ack_n = 1'b0;
    do_reset;
    disp_active_n = 1'b0;
    sb.push_back('{rdata: 8'h00, err: 1'b1, chk_rd: 1'b0});
    host_rw = 1'b1; host_addr = 24'h000999; host_sel_n = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if (!vram_oe_n_to || !vram_we_n_to) strobes++;
      if (!host_ack_n_to) begin ac = k; er = host_err_to; main_ack_n = host_ack_n; break; end
    end
    e = sb.pop_front();
    n_checks++;
    if ((ac < 15) || (ac > 18) || (er !== e.err) || (strobes != 0)) begin
      n_fail++;
      $display("[TB] FAIL timeout_ack: got ack=%0d err=%b strobes=%0d expected 15..18/%b/0", ac, er, strobes, e.err);
    end
    n_checks++;
    if (main_ack_n !== 1'b1) begin
      n_fail++; $display("[TB] FAIL timeout_default: got ack_n=%b expected 1", main_ack_n);
    end
    host_sel_n = 1'b1;
    tick;
    n_checks++;
    if ((host_ack_n_to !== 1'b1) || (host_err_to !== 1'b0) || (collision_cnt_to !== 8'd0)) begin
      n_fail++;
      $display("[TB] FAIL timeout_release: got ack_n=%b err=%b coll=%0d expected 1/0/0",
               host_ack_n_to, host_err_to, collision_cnt_to);
    end
    disp_active_n = 1'b1;
    tick;
  endtask

  task automatic test_strobe_invariant;
    n_checks++;
    if (strobe_bad != 0) begin
      n_fail++; $display("[TB] FAIL strobe_overlap: got %0d cycles expected 0", strobe_bad);
    end
  endtask

  initial begin
    reset_in = 1'b1; disp_active_n = 1'b1; disp_hold = 1'b0; disp_addr = '0;
    host_sel_n = 1'b1; host_rw = 1'b1; host_addr = '0; host_wdata = '0; vram_rdata = '0;
    test_reset;
    test_read;
    test_write;
    test_priority;
    test_collision;
    test_withdraw;
    test_back_to_back;
    test_reset_mid_write;
    test_timeout;
    test_strobe_invariant;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
